// File: rtl/mycpu_pkg.sv
// ==== mycpu_pkg : shared fetch-stage constants, state encoding and buffer entry type ====
// ==== rev 1.0 ; MYCPU_IF_DELAY_SLOT_EN adds the DSLOT state                           ====
`default_nettype none

package mycpu_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;

    localparam logic [1:0] ST_RESET = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
`ifdef MYCPU_IF_DELAY_SLOT_EN
    localparam logic [1:0] ST_DSLOT = 2'd2;
`endif

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } if_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

`default_nettype wire

// File: rtl/mycpu_if_buf.sv
// ==== mycpu_if_buf : 2-entry in-order instruction buffer; head is the oldest entry ====
// ==== rev 1.0                                                                      ====
`default_nettype none

module mycpu_if_buf
    import mycpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       pop,
    input  logic       flush,
    input  logic       keep_one,
    input  logic       push,
    input  if_entry_t  push_entry,
    output if_entry_t  head,
    output logic [1:0] count
);

    if_entry_t  ent0;
    if_entry_t  ent1;
    logic [1:0] cnt;
    logic [1:0] cnt_pop;
    logic [1:0] cnt_trim;
    if_entry_t  ent0_pop;

    // Order within a cycle: pop the head, then trim (flush / keep only head), then push at the tail.
    always_comb begin
        cnt_pop  = (pop && (cnt != 2'd0)) ? cnt - 2'd1 : cnt;
        ent0_pop = pop ? ent1 : ent0;
        cnt_trim = cnt_pop;
        if (flush) begin
            cnt_trim = 2'd0;
        end else if (keep_one && (cnt_pop > 2'd1)) begin
            cnt_trim = 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt  <= 2'd0;
            ent0 <= '0;
            ent1 <= '0;
        end else begin
            cnt  <= cnt_trim + {1'b0, push};
            ent0 <= (push && (cnt_trim == 2'd0)) ? push_entry : ent0_pop;
            ent1 <= (push && (cnt_trim == 2'd1)) ? push_entry : ent1;
        end
    end

    assign head  = ent0;
    assign count = cnt;

endmodule

`default_nettype wire

// File: rtl/mycpu_if.sv
// ==== mycpu_if : instruction fetch stage with 1-cycle SRAM, 2-entry buffer and redirect ====
// ==== rev 1.0 ; MYCPU_IF_DELAY_SLOT_EN keeps the branch delay slot                      ====
`default_nettype none

module mycpu_if
    import mycpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    output logic        inst_sram_en,
    output logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_rdata,
    input  logic        id_ready,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic        if_valid,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc
);

    logic [1:0]  state;
    logic [1:0]  state_next;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic        resp_vld;
    logic [31:0] resp_pc;
    logic        issue;
    logic [31:0] issue_addr;
    logic [31:0] tgt;
    logic        from_buf;
    logic        xfer;
    logic        resp_live;
    logic [2:0]  pend_cnt;
    logic        buf_pop;
    logic        buf_flush;
    logic        buf_keep;
    logic        buf_push;
    if_entry_t   buf_head;
    logic [1:0]  buf_count;
    if_entry_t   resp_entry;
`ifdef MYCPU_IF_DELAY_SLOT_EN
    logic        rem_buf;
`endif

    assign tgt        = word_align(br_target);
    assign from_buf   = (buf_count != 2'd0);
    assign if_valid   = from_buf || resp_vld;
    assign xfer       = if_valid && id_ready;
    assign buf_pop    = xfer && from_buf;
    // An arriving response bypasses the buffer when it is the head and decode takes it.
    assign resp_live  = resp_vld && !(xfer && !from_buf);
    assign pend_cnt   = {1'b0, buf_count} - {2'b00, buf_pop} + {2'b00, resp_live};
    assign resp_entry = '{pc: resp_pc, inst: inst_sram_rdata};
`ifdef MYCPU_IF_DELAY_SLOT_EN
    assign rem_buf    = (buf_count > {1'b0, buf_pop});
`endif

    always_comb begin
        if (from_buf) begin
            if_pc   = buf_head.pc;
            if_inst = buf_head.inst;
        end else if (resp_vld) begin
            if_pc   = resp_pc;
            if_inst = inst_sram_rdata;
        end else begin
            if_pc   = 32'd0;
            if_inst = 32'd0;
        end
    end

    always_comb begin
        buf_flush  = 1'b0;
        buf_keep   = 1'b0;
        buf_push   = resp_live;
        issue      = rst && (pend_cnt < 3'd2);
        issue_addr = pc;
        pc_next    = pc + 32'd4;
        state_next = state;
        if (state == ST_RESET) begin
            state_next = ST_RUN;
        end
`ifdef MYCPU_IF_DELAY_SLOT_EN
        if ((state == ST_DSLOT) && resp_vld) begin
            state_next = ST_RUN;
        end
        if (br_taken) begin
            issue = rst;
            if (rem_buf) begin
                // Delay slot already buffered: drop everything behind it.
                buf_keep   = 1'b1;
                buf_push   = 1'b0;
                issue_addr = tgt;
                pc_next    = tgt + 32'd4;
            end else if (resp_live) begin
                issue_addr = tgt;
                pc_next    = tgt + 32'd4;
            end else begin
                // Delay slot not fetched yet: fetch it now, target goes next.
                issue_addr = pc;
                pc_next    = tgt;
                state_next = ST_DSLOT;
            end
        end
`else
        if (br_taken) begin
            buf_flush  = 1'b1;
            buf_push   = 1'b0;
            issue      = rst;
            issue_addr = tgt;
            pc_next    = tgt + 32'd4;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_RESET;
            pc       <= word_align(RESET_PC);
            resp_vld <= 1'b0;
            resp_pc  <= 32'd0;
        end else begin
            state    <= state_next;
            resp_vld <= issue;
            if (issue) begin
                resp_pc <= issue_addr;
                pc      <= pc_next;
            end
        end
    end

    mycpu_if_buf u_buf (
        .clk        (clk),
        .rst        (rst),
        .pop        (buf_pop),
        .flush      (buf_flush),
        .keep_one   (buf_keep),
        .push       (buf_push),
        .push_entry (resp_entry),
        .head       (buf_head),
        .count      (buf_count)
    );

    assign inst_sram_en   = issue;
    assign inst_sram_addr = issue_addr;

endmodule

`default_nettype wire

// File: tb/tb_mycpu_if.sv
// ==== tb_mycpu_if : self-checking bench for mycpu_if against a program-order stream model ====
// ==== rev 1.0 ; honours MYCPU_IF_DELAY_SLOT_EN                                            ====
`default_nettype none

module tb_mycpu_if;

    localparam logic [31:0] RST_PC = 32'hBFC0_0000;
`ifdef MYCPU_IF_DELAY_SLOT_EN
    localparam bit DSLOT = 1'b1;
`else
    localparam bit DSLOT = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        inst_sram_en;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_rdata;
    logic        id_ready;
    logic        br_taken;
    logic [31:0] br_target;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [31:0] if_pc;

    int          n_checks = 0;
    int          n_fail   = 0;

    // Model: PC of the next instruction decode should receive, plus a pending redirect after the delay slot.
    logic [31:0] m_next;
    logic        m_redir;
    logic [31:0] m_tgt;
    logic        hold_prev;
    logic [31:0] hold_pc;
    logic [31:0] hold_inst;

    mycpu_if #(.RESET_PC(RST_PC)) dut (
        .clk             (clk),
        .rst             (rst),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_rdata (inst_sram_rdata),
        .id_ready        (id_ready),
        .br_taken        (br_taken),
        .br_target       (br_target),
        .if_valid        (if_valid),
        .if_inst         (if_inst),
        .if_pc           (if_pc)
    );

    function automatic logic [31:0] code_of(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        inst_sram_rdata <= inst_sram_en ? code_of(inst_sram_addr) : $urandom;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance the model by the cycle about to end, then move to the next negedge.
    task automatic model_step();
        logic [31:0] n;
        n = m_next;
        if (if_valid && id_ready) begin
            if (m_redir) begin
                n       = m_tgt;
                m_redir = 1'b0;
            end else begin
                n = n + 32'd4;
            end
        end
        if (br_taken) begin
            if (DSLOT) begin
                m_redir = 1'b1;
                m_tgt   = {br_target[31:2], 2'b00};
            end else begin
                n = {br_target[31:2], 2'b00};
            end
        end
        m_next    = n;
        hold_prev = if_valid && !id_ready && !br_taken;
        hold_pc   = if_pc;
        hold_inst = if_inst;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        id_ready  = 1'b0;
        br_taken  = 1'b0;
        br_target = 32'd0;
        repeat (2) @(negedge clk);
        m_next    = RST_PC;
        m_redir   = 1'b0;
        hold_prev = 1'b0;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            id_ready  = 1'($urandom_range(0, 1));
            br_taken  = 1'($urandom_range(0, 1));
            br_target = $urandom;
            #1;
            n_checks++; if (inst_sram_en !== 1'b0) begin n_fail++; $display("FAIL reset_en: got %b want 0", inst_sram_en); end
            n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", if_valid); end
            n_checks++; if (if_inst !== 32'd0) begin n_fail++; $display("FAIL reset_inst: got %h want 0", if_inst); end
            n_checks++; if (if_pc !== 32'd0) begin n_fail++; $display("FAIL reset_pc: got %h want 0", if_pc); end
            @(negedge clk);
        end
        m_next = RST_PC; m_redir = 1'b0; hold_prev = 1'b0;
        rst = 1'b1; id_ready = 1'b1; br_taken = 1'b0;
        #1;
        n_checks++; if (inst_sram_en !== 1'b1 || inst_sram_addr !== RST_PC) begin n_fail++; $display("FAIL first_req: en %b addr %h want 1 %h", inst_sram_en, inst_sram_addr, RST_PC); end
        model_step();
        for (int k = 0; k < 6; k++) begin
            #1;
            n_checks++; if (if_valid !== 1'b1 || if_pc !== RST_PC + 32'd4 * 32'(k)) begin n_fail++; $display("FAIL seq_pc: valid %b pc %h want 1 %h", if_valid, if_pc, RST_PC + 32'd4 * 32'(k)); end
            n_checks++; if (if_inst !== code_of(RST_PC + 32'd4 * 32'(k))) begin n_fail++; $display("FAIL seq_inst: got %h want %h", if_inst, code_of(RST_PC + 32'd4 * 32'(k))); end
            n_checks++; if (inst_sram_en !== 1'b1 || inst_sram_addr !== RST_PC + 32'd4 * 32'(k + 1)) begin n_fail++; $display("FAIL seq_addr: en %b addr %h want 1 %h", inst_sram_en, inst_sram_addr, RST_PC + 32'd4 * 32'(k + 1)); end
            model_step();
        end
    endtask

    task automatic test_stall();
        logic [31:0] frozen;
        for (int k = 0; k < 3; k++) begin
            id_ready = 1'b1; br_taken = 1'b0; #1;
            n_checks++; if (if_valid !== 1'b1 || if_pc !== m_next) begin n_fail++; $display("FAIL stall_warm: valid %b pc %h want 1 %h", if_valid, if_pc, m_next); end
            model_step();
        end
        frozen = m_next;
        for (int k = 0; k < 3; k++) begin
            id_ready = 1'b0; #1;
            n_checks++; if (if_valid !== 1'b1 || if_pc !== frozen || if_inst !== code_of(frozen)) begin n_fail++; $display("FAIL stall_hold: valid %b pc %h inst %h want 1 %h %h", if_valid, if_pc, if_inst, frozen, code_of(frozen)); end
            if (k == 2) begin
                n_checks++; if (inst_sram_en !== 1'b0) begin n_fail++; $display("FAIL stall_backpressure: en %b want 0", inst_sram_en); end
            end
            model_step();
        end
        for (int k = 0; k < 6; k++) begin
            id_ready = 1'b1; #1;
            n_checks++; if (if_valid !== 1'b1 || if_pc !== frozen + 32'd4 * 32'(k)) begin n_fail++; $display("FAIL stall_resume: valid %b pc %h want 1 %h", if_valid, if_pc, frozen + 32'd4 * 32'(k)); end
            n_checks++; if (if_inst !== code_of(frozen + 32'd4 * 32'(k))) begin n_fail++; $display("FAIL stall_inst: got %h want %h", if_inst, code_of(frozen + 32'd4 * 32'(k))); end
            model_step();
        end
    endtask

    task automatic test_branch();
        logic        found;
        logic [31:0] got   [3];
        logic [31:0] exp_b [3];
        int          got_n;
`ifdef MYCPU_IF_DELAY_SLOT_EN
        exp_b[0] = 32'hBFC0_0008; exp_b[1] = 32'hBFC0_0100; exp_b[2] = 32'hBFC0_0104;
`else
        exp_b[0] = 32'hBFC0_0100; exp_b[1] = 32'hBFC0_0104; exp_b[2] = 32'hBFC0_0108;
`endif
        for (int i = 0; i < 3; i++) got[i] = 32'd0;
        do_reset();
        rst   = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            id_ready = 1'b1; br_taken = 1'b0; #1;
            if (if_valid && if_pc == RST_PC + 32'd8) begin
                id_ready = 1'b0; br_taken = 1'b1; br_target = 32'hBFC0_0100; found = 1'b1;
                #1;
            end
            model_step();
        end
        br_taken = 1'b0;
        n_checks++; if (found !== 1'b1) begin n_fail++; $display("FAIL branch_setup: BFC00008 arrival seen %b want 1", found); end
        got_n = 0;
        for (int k = 0; k < 12 && got_n < 3; k++) begin
            id_ready = 1'b1; #1;
            if (if_valid) begin
                got[got_n] = if_pc;
                got_n++;
            end
            model_step();
        end
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (got[i] !== exp_b[i]) begin n_fail++; $display("FAIL branch_seq[%0d]: got %h want %h", i, got[i], exp_b[i]); end
        end
    endtask

    task automatic test_wrap();
        logic saw;
        logic done;
        saw  = 1'b0;
        done = 1'b0;
        id_ready = 1'b1; br_taken = 1'b1; br_target = 32'hFFFF_FFFE; #1;
        if (inst_sram_en && inst_sram_addr == 32'hFFFF_FFFC) saw = 1'b1;
        model_step();
        br_taken = 1'b0;
        for (int k = 0; k < 10; k++) begin
            id_ready = 1'b1; #1;
            if (if_valid) begin
                n_checks++; if (if_pc !== m_next) begin n_fail++; $display("FAIL wrap_pc: got %h want %h", if_pc, m_next); end
            end
            if (inst_sram_en && saw && !done) begin
                n_checks++; if (inst_sram_addr !== 32'd0) begin n_fail++; $display("FAIL wrap_addr: got %h want 00000000", inst_sram_addr); end
                done = 1'b1;
            end
            if (inst_sram_en && inst_sram_addr == 32'hFFFF_FFFC) saw = 1'b1;
            model_step();
        end
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL wrap_seen: request after FFFFFFFC seen %b want 1", done); end
    endtask

    task automatic test_reset_midstream();
        for (int k = 0; k < 3; k++) begin
            id_ready = 1'b1; br_taken = 1'b0; #1;
            n_checks++; if (if_valid !== 1'b1 || if_pc !== m_next) begin n_fail++; $display("FAIL midrst_stream: valid %b pc %h want 1 %h", if_valid, if_pc, m_next); end
            model_step();
        end
        #1;
        n_checks++; if (inst_sram_en !== 1'b1) begin n_fail++; $display("FAIL midrst_pre: en %b want 1", inst_sram_en); end
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        n_checks++; if (if_valid !== 1'b0 || inst_sram_en !== 1'b0) begin n_fail++; $display("FAIL midrst_async: valid %b en %b want 0 0", if_valid, inst_sram_en); end
        n_checks++; if (if_pc !== 32'd0 || if_inst !== 32'd0) begin n_fail++; $display("FAIL midrst_outs: pc %h inst %h want 0 0", if_pc, if_inst); end
        #1 rst = 1'b1;
        #1;
        n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_stale: valid %b want 0", if_valid); end
        n_checks++; if (inst_sram_en !== 1'b1 || inst_sram_addr !== RST_PC) begin n_fail++; $display("FAIL midrst_req: en %b addr %h want 1 %h", inst_sram_en, inst_sram_addr, RST_PC); end
        m_next = RST_PC; m_redir = 1'b0; hold_prev = 1'b0;
        @(negedge clk);
        model_step();
        for (int k = 0; k < 4; k++) begin
            id_ready = 1'b1; #1;
            n_checks++; if (if_valid !== 1'b1 || if_pc !== RST_PC + 32'd4 * 32'(k)) begin n_fail++; $display("FAIL midrst_seq: valid %b pc %h want 1 %h", if_valid, if_pc, RST_PC + 32'd4 * 32'(k)); end
            n_checks++; if (if_inst !== code_of(RST_PC + 32'd4 * 32'(k))) begin n_fail++; $display("FAIL midrst_inst: got %h want %h", if_inst, code_of(RST_PC + 32'd4 * 32'(k))); end
            model_step();
        end
    endtask

    task automatic test_random();
        int xfers;
        xfers     = 0;
        hold_prev = 1'b0;
        for (int k = 0; k < 500; k++) begin
            id_ready  = ($urandom_range(0, 3) != 0);
            br_taken  = !m_redir && ($urandom_range(0, 9) == 0);
            br_target = RST_PC + 32'($urandom_range(0, 4095));
            #1;
            if (hold_prev) begin
                n_checks++; if (if_valid !== 1'b1 || if_pc !== hold_pc || if_inst !== hold_inst) begin n_fail++; $display("FAIL rand_hold: valid %b pc %h inst %h want 1 %h %h", if_valid, if_pc, if_inst, hold_pc, hold_inst); end
            end
            if (if_valid) begin
                n_checks++; if (if_pc !== m_next) begin n_fail++; $display("FAIL rand_pc: got %h want %h", if_pc, m_next); end
                n_checks++; if (if_inst !== code_of(m_next)) begin n_fail++; $display("FAIL rand_inst: got %h want %h", if_inst, code_of(m_next)); end
                if (id_ready) xfers++;
            end
            if (inst_sram_en) begin
                n_checks++; if (inst_sram_addr[1:0] !== 2'b00) begin n_fail++; $display("FAIL rand_align: addr %h want low bits 00", inst_sram_addr); end
            end
            model_step();
        end
        br_taken = 1'b0;
        n_checks++; if (xfers < 250) begin n_fail++; $display("FAIL rand_progress: %0d transfers want at least 250", xfers); end
    endtask

    initial begin
        rst       = 1'b0;
        id_ready  = 1'b0;
        br_taken  = 1'b0;
        br_target = 32'd0;
        m_next    = RST_PC;
        m_redir   = 1'b0;
        m_tgt     = 32'd0;
        hold_prev = 1'b0;
        hold_pc   = 32'd0;
        hold_inst = 32'd0;
        @(negedge clk);
        test_reset();
        test_stall();
        test_branch();
        test_wrap();
        test_reset_midstream();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
